loc_arbiter: RTL and testbench
==============================

# loc_arbiter

Round-robin arbiter that shares one spike locator (the divider-based x/y centroid stage) among `N_REQ` accumulator streams. It grants one requester at a time and forwards that requester's accumulated sums to the locator. It then waits for the locator result and returns it on a single result stream, tagged with the requester index. Only one transaction is in flight at any time, which matches the locator's one-at-a-time IDLE/CALC/SEND behaviour.

## Interface
- `N_REQ`, 4: number of requesters; must be ≥2.
- `ID_W`, `$clog2(N_REQ)`: width of the requester tag.
- `TIME_W`, 32: spike timestamp width.
- `XACC_W`, 28: x and y accumulator width.
- `AACC_W`, 25: amplitude accumulator width.
- `XY_W`, 11: located coordinate width.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `LOC_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_req_time`  in  `N_REQ*TIME_W`  per-requester timestamp; requester i occupies slice i.
- `s_req_tx`, `s_req_ty`  in  `N_REQ*XACC_W`  per-requester x and y accumulators.
- `s_req_ta`  in  `N_REQ*AACC_W`  per-requester amplitude accumulator.
- `s_req_tvalid`, `s_req_tlast`  in  `N_REQ`  per-requester valid and last.
- `s_req_tready`  out  `N_REQ`  per-requester ready.
- `m_loc_time`, `m_loc_tx`, `m_loc_ty`, `m_loc_ta`  out  `TIME_W`/`XACC_W`/`XACC_W`/`AACC_W`  operands to the locator.
- `m_loc_tvalid`  out  1  operand valid to the locator.
- `m_loc_tlast`  out  1  always driven 0; tlast is handled inside this block.
- `m_loc_tready`  in  1  locator accepts operands.
- `s_loc_tx`, `s_loc_ty`  in  `XY_W`  locator result.
- `s_loc_tvalid`  in  1  locator result valid.
- `s_loc_tready`  out  1  constant 1.
- `m_res_time`, `m_res_tx`, `m_res_ty`, `m_res_tid`  out  `TIME_W`/`XY_W`/`XY_W`/`ID_W`  registered result and its requester tag.
- `m_res_tvalid`, `m_res_tlast`, `m_res_terr`  out  1  registered result valid, last and error flags.
- `m_res_tready`  in  1  downstream accepts the result.

## Operation
- State machine: IDLE → ISSUE → WAIT → RETURN → IDLE.
- **IDLE**
  - If any `s_req_tvalid` bit is set, pick the first requester at or above `rr_ptr`, wrapping modulo `N_REQ`.
  - Register its index as `grant` and go to ISSUE.
  - If no valid bit is set, stay in IDLE.
- **ISSUE**
  - `m_loc_*` operands are combinationally muxed from requester `grant`.
  - `m_loc_tvalid = s_req_tvalid[grant]`.
  - `s_req_tready[grant] = m_loc_tready`; all other `s_req_tready` bits are 0.
  - On handshake: capture the time and tlast of requester `grant`, set `rr_ptr = (grant+1) mod N_REQ`, go to WAIT.
- **WAIT**
  - On `s_loc_tvalid`, load `m_res_tx` and `m_res_ty` from `s_loc_tx` and `s_loc_ty`.
  - In the same load: `m_res_time` = captured time, `m_res_tid = grant`, `m_res_tlast` = captured tlast, `m_res_terr = 0`.
  - Then go to RETURN.
- **RETURN**
  - `m_res_tvalid = 1`.
  - On `m_res_tready`: clear `m_res_tvalid` and go to IDLE.
  - The payload holds stable while `m_res_tvalid` is 1.
- `s_req_tready` is all-zero outside ISSUE.
- `s_loc_tvalid` pulses arriving outside WAIT are dropped.
- If `s_req_tvalid[grant]` falls while in ISSUE (a protocol violation), the arbiter still waits in ISSUE. No recovery is required.
- Reset mid-operation: the state machine returns to IDLE, `rr_ptr = 0`, and all outputs take their reset values. Any in-flight locator result is later dropped.
- Reset values: `s_req_tready = 0`, `m_loc_tvalid = 0`, `m_res_tvalid = 0`, `m_res_tlast = 0`, `m_res_terr = 0`. All `m_res_*` payload registers reset to 0.

## Timing
- An IDLE grant takes one cycle. `m_loc_tvalid` is first asserted the cycle after the requester's `s_req_tvalid` is sampled in IDLE.
- Result latency: locator latency + 1 cycle from `s_loc_tvalid` to `m_res_tvalid`.
- Minimum period per transaction: 4 cycles + locator latency.
- Transaction boundary: on an `m_res` handshake the state returns to IDLE. The next grant is decided in that IDLE cycle, so a back-to-back requester sees `s_req_tready` two cycles after the `m_res` handshake.
- Fairness: under continuous contention, grants rotate 0,1,…,N_REQ−1,0.
- Simultaneous events:
  - Requests that arrive during ISSUE, WAIT or RETURN wait for the next IDLE.
  - The `rr_ptr` update in ISSUE takes effect at the next IDLE.

## Configuration
- `LOC_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If it reaches `TIMEOUT` with no `s_loc_tvalid`, the result registers load with the captured time, `tid = grant`, the captured tlast, `tx = ty = 0` and `m_res_terr = 1`. The state then goes to RETURN.
  - If `s_loc_tvalid` arrives in the same cycle as the expiry, the real result wins.
  - A late locator result that arrives after expiry is dropped.
- `LOC_ARB_TIMEOUT_EN` undefined: there is no counter, WAIT waits indefinitely, and `m_res_terr` is tied to 0.

## Test plan
- Single request: requester 2 with time=100, tx=500, ty=300, ta=10, tlast=1; locator returns 50/30 after 33 cycles → one `m_res` beat with time=100, tx=50, ty=30, tid=2, tlast=1, terr=0.
- All 4 requesters valid continuously for 8 transactions → tid sequence 0,1,2,3,0,1,2,3; each requester sees exactly 2 handshakes.
- `m_res_tready` held low for 20 cycles → `m_res_tvalid` stays 1 with a stable payload; no new `s_req_tready` is asserted until the result handshake.
- `m_loc_tready` held low for 5 cycles in ISSUE → `s_req_tready[grant]` stays 0 for those cycles; the handshake completes only when `m_loc_tready` rises.
- `rst_n` asserted during WAIT, then released; locator returns its stale result 3 cycles later → no `m_res_tvalid`; the next request gets grant 0 (assuming requester 0 is valid) and its result is correct.
- With `LOC_ARB_TIMEOUT_EN` and `TIMEOUT`=64: locator never responds → `m_res_tvalid` with terr=1, tx=ty=0, exactly 65 cycles after WAIT entry. A locator result injected afterwards is dropped.

Source files
------------

// File: rtl/loc_arbiter.sv
// Round-robin arbiter sharing one spike locator among N_REQ accumulator streams.
// Optional WAIT watchdog is enabled by defining LOC_ARB_TIMEOUT_EN.
module loc_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIME_W  = 32,
  parameter int XACC_W  = 28,
  parameter int AACC_W  = 25,
  parameter int XY_W    = 11,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ*TIME_W-1:0]  s_req_time,
  input  logic [N_REQ*XACC_W-1:0]  s_req_tx,
  input  logic [N_REQ*XACC_W-1:0]  s_req_ty,
  input  logic [N_REQ*AACC_W-1:0]  s_req_ta,
  input  logic [N_REQ-1:0]         s_req_tvalid,
  input  logic [N_REQ-1:0]         s_req_tlast,
  output logic [N_REQ-1:0]         s_req_tready,
  output logic [TIME_W-1:0]        m_loc_time,
  output logic [XACC_W-1:0]        m_loc_tx,
  output logic [XACC_W-1:0]        m_loc_ty,
  output logic [AACC_W-1:0]        m_loc_ta,
  output logic                     m_loc_tvalid,
  output logic                     m_loc_tlast,
  input  logic                     m_loc_tready,
  input  logic [XY_W-1:0]          s_loc_tx,
  input  logic [XY_W-1:0]          s_loc_ty,
  input  logic                     s_loc_tvalid,
  output logic                     s_loc_tready,
  output logic [TIME_W-1:0]        m_res_time,
  output logic [XY_W-1:0]          m_res_tx,
  output logic [XY_W-1:0]          m_res_ty,
  output logic [ID_W-1:0]          m_res_tid,
  output logic                     m_res_tvalid,
  output logic                     m_res_tlast,
  output logic                     m_res_terr,
  input  logic                     m_res_tready
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    grant_reg, rr_ptr_reg, pick;
  logic               any_req;
  logic [TIME_W-1:0]  cap_time_reg;
  logic               cap_last_reg;
  logic [TIME_W-1:0]  res_time_reg;
  logic [XY_W-1:0]    res_tx_reg, res_ty_reg;
  logic [ID_W-1:0]    res_tid_reg;
  logic               res_valid_reg, res_last_reg, res_err_reg;
  logic               issue_hs, res_load, wd_expired;

  logic [TIME_W-1:0]  req_time [N_REQ];
  logic [XACC_W-1:0]  req_tx   [N_REQ];
  logic [XACC_W-1:0]  req_ty   [N_REQ];
  logic [AACC_W-1:0]  req_ta   [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_time[gi] = s_req_time[gi*TIME_W +: TIME_W];
    assign req_tx[gi]   = s_req_tx[gi*XACC_W +: XACC_W];
    assign req_ty[gi]   = s_req_ty[gi*XACC_W +: XACC_W];
    assign req_ta[gi]   = s_req_ta[gi*AACC_W +: AACC_W];
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (s_req_tvalid[(int'(rr_ptr_reg) + off) % N_REQ]) begin
        pick    = ID_W'((int'(rr_ptr_reg) + off) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  assign m_loc_time   = req_time[grant_reg];
  assign m_loc_tx     = req_tx[grant_reg];
  assign m_loc_ty     = req_ty[grant_reg];
  assign m_loc_ta     = req_ta[grant_reg];
  assign m_loc_tvalid = (state_reg == S_ISSUE) && s_req_tvalid[grant_reg];
  assign m_loc_tlast  = 1'b0;
  assign s_loc_tready = 1'b1;
  assign issue_hs     = m_loc_tvalid && m_loc_tready;

  always_comb begin
    s_req_tready = '0;
    if (state_reg == S_ISSUE) s_req_tready[grant_reg] = m_loc_tready;
  end

`ifdef LOC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
    end else if (issue_hs) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == S_WAIT && wd_cnt_reg != CNT_W'(TIMEOUT)) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign wd_expired = (state_reg == S_WAIT) && (wd_cnt_reg == CNT_W'(TIMEOUT));
`else
  assign wd_expired = 1'b0;
`endif

  // A real locator result takes priority over a same-cycle watchdog expiry.
  assign res_load = (state_reg == S_WAIT) && (s_loc_tvalid || wd_expired);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (any_req)      state_next = S_ISSUE;
      S_ISSUE:  if (issue_hs)     state_next = S_WAIT;
      S_WAIT:   if (res_load)     state_next = S_RETURN;
      S_RETURN: if (m_res_tready) state_next = S_IDLE;
      default:                    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      cap_time_reg  <= '0;
      cap_last_reg  <= 1'b0;
      res_time_reg  <= '0;
      res_tx_reg    <= '0;
      res_ty_reg    <= '0;
      res_tid_reg   <= '0;
      res_valid_reg <= 1'b0;
      res_last_reg  <= 1'b0;
      res_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && any_req) grant_reg <= pick;
      if (issue_hs) begin
        cap_time_reg <= req_time[grant_reg];
        cap_last_reg <= s_req_tlast[grant_reg];
        rr_ptr_reg   <= (grant_reg == ID_W'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
      end
      if (res_load) begin
        res_time_reg  <= cap_time_reg;
        res_tid_reg   <= grant_reg;
        res_last_reg  <= cap_last_reg;
        res_tx_reg    <= s_loc_tvalid ? s_loc_tx : '0;
        res_ty_reg    <= s_loc_tvalid ? s_loc_ty : '0;
        res_err_reg   <= !s_loc_tvalid;
        res_valid_reg <= 1'b1;
      end else if (state_reg == S_RETURN && m_res_tready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign m_res_time   = res_time_reg;
  assign m_res_tx     = res_tx_reg;
  assign m_res_ty     = res_ty_reg;
  assign m_res_tid    = res_tid_reg;
  assign m_res_tvalid = res_valid_reg;
  assign m_res_tlast  = res_last_reg;
  assign m_res_terr   = res_err_reg;

endmodule

// File: tb/tb_loc_arbiter.sv
// Scoreboard bench for loc_arbiter with a behavioural divider-style locator model.
module tb_loc_arbiter;
  localparam int N_REQ = 4, ID_W = 2, TIME_W = 32, XACC_W = 28, AACC_W = 25, XY_W = 11, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REQ*TIME_W-1:0] s_req_time;
  logic [N_REQ*XACC_W-1:0] s_req_tx, s_req_ty;
  logic [N_REQ*AACC_W-1:0] s_req_ta;
  logic [N_REQ-1:0] s_req_tvalid, s_req_tlast, s_req_tready;
  logic [TIME_W-1:0] m_loc_time;
  logic [XACC_W-1:0] m_loc_tx, m_loc_ty;
  logic [AACC_W-1:0] m_loc_ta;
  logic m_loc_tvalid, m_loc_tlast, m_loc_tready;
  logic [XY_W-1:0] s_loc_tx, s_loc_ty;
  logic s_loc_tvalid, s_loc_tready;
  logic [TIME_W-1:0] m_res_time;
  logic [XY_W-1:0] m_res_tx, m_res_ty;
  logic [ID_W-1:0] m_res_tid;
  logic m_res_tvalid, m_res_tlast, m_res_terr, m_res_tready;

  always #5 clk = ~clk;

  loc_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIME_W(TIME_W), .XACC_W(XACC_W), .AACC_W(AACC_W),
                .XY_W(XY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_time(s_req_time), .s_req_tx(s_req_tx), .s_req_ty(s_req_ty), .s_req_ta(s_req_ta),
    .s_req_tvalid(s_req_tvalid), .s_req_tlast(s_req_tlast), .s_req_tready(s_req_tready),
    .m_loc_time(m_loc_time), .m_loc_tx(m_loc_tx), .m_loc_ty(m_loc_ty), .m_loc_ta(m_loc_ta),
    .m_loc_tvalid(m_loc_tvalid), .m_loc_tlast(m_loc_tlast), .m_loc_tready(m_loc_tready),
    .s_loc_tx(s_loc_tx), .s_loc_ty(s_loc_ty), .s_loc_tvalid(s_loc_tvalid), .s_loc_tready(s_loc_tready),
    .m_res_time(m_res_time), .m_res_tx(m_res_tx), .m_res_ty(m_res_ty), .m_res_tid(m_res_tid),
    .m_res_tvalid(m_res_tvalid), .m_res_tlast(m_res_tlast), .m_res_terr(m_res_terr),
    .m_res_tready(m_res_tready)
  );

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [XY_W-1:0]   x;
    logic [XY_W-1:0]   y;
    logic [ID_W-1:0]   id;
    logic              last;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0, cyc = 0, loc_fire_cyc = -1, loc_hs_cnt = 0;
  int req_left[N_REQ];
  int hs_cnt[N_REQ];
  int loc_lat = 4, loc_cnt = 0;
  bit loc_busy = 0, loc_mute = 0;
  logic [XY_W-1:0] pend_x, pend_y;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input logic [TIME_W-1:0] t, input logic [XY_W-1:0] x, input logic [XY_W-1:0] y,
                          input logic [ID_W-1:0] id, input logic last, input logic err);
    exp_t e;
    e.t = t; e.x = x; e.y = y; e.id = id; e.last = last; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [TIME_W-1:0] t, input logic [XACC_W-1:0] x,
                         input logic [XACC_W-1:0] y, input logic [AACC_W-1:0] a, input logic last, input int cnt);
    s_req_time[i*TIME_W +: TIME_W] = t;
    s_req_tx[i*XACC_W +: XACC_W]   = x;
    s_req_ty[i*XACC_W +: XACC_W]   = y;
    s_req_ta[i*AACC_W +: AACC_W]   = a;
    s_req_tlast[i]  = last;
    req_left[i]     = cnt;
    s_req_tvalid[i] = 1'b1;
  endtask

  // One clock: sample handshakes mid-cycle, then update requesters and the locator model after the edge.
  task automatic tick();
    logic [N_REQ-1:0] req_hs;
    logic loc_hs, res_hs;
    exp_t e;
    @(negedge clk);
    req_hs = s_req_tvalid & s_req_tready;
    loc_hs = m_loc_tvalid && m_loc_tready;
    res_hs = m_res_tvalid && m_res_tready;
    if (res_hs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", 64'(m_res_tvalid), 0);
      end else begin
        e = exp_q.pop_front();
        $display("result tid=%0d time=%0d x=%0d y=%0d last=%0d err=%0d", m_res_tid, m_res_time,
                 m_res_tx, m_res_ty, m_res_tlast, m_res_terr);
        check("res_time", 64'(m_res_time), 64'(e.t));
        check("res_tx", 64'(m_res_tx), 64'(e.x));
        check("res_ty", 64'(m_res_ty), 64'(e.y));
        check("res_tid", 64'(m_res_tid), 64'(e.id));
        check("res_tlast", 64'(m_res_tlast), 64'(e.last));
        check("res_terr", 64'(m_res_terr), 64'(e.err));
      end
    end
    if (loc_hs) begin
      loc_hs_cnt++;
      if (!loc_mute) begin
        pend_x   = XY_W'(m_loc_tx / XACC_W'(m_loc_ta));
        pend_y   = XY_W'(m_loc_ty / XACC_W'(m_loc_ta));
        loc_busy = 1'b1;
        loc_cnt  = loc_lat;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    s_loc_tvalid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_hs[i]) begin
        hs_cnt[i]++;
        req_left[i]--;
        if (req_left[i] <= 0) s_req_tvalid[i] = 1'b0;
      end
    end
    if (loc_busy) begin
      loc_cnt--;
      if (loc_cnt <= 0) begin
        s_loc_tvalid = 1'b1;
        s_loc_tx     = pend_x;
        s_loc_ty     = pend_y;
        loc_busy     = 1'b0;
        loc_fire_cyc = cyc;
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_loc_hs(input int max);
    int n = 0;
    int start = loc_hs_cnt;
    while (loc_hs_cnt == start && n < max) begin
      tick();
      n++;
    end
    check("loc_hs_wait", 64'(loc_hs_cnt - start), 1);
  endtask

  initial begin
    int n;
    s_req_time = '0; s_req_tx = '0; s_req_ty = '0; s_req_ta = '0;
    s_req_tvalid = '0; s_req_tlast = '0;
    s_loc_tx = '0; s_loc_ty = '0; s_loc_tvalid = 1'b0;
    m_loc_tready = 1'b1; m_res_tready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      req_left[i] = 0;
      hs_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_req_tready", 64'(s_req_tready), 0);
    check("rst_m_loc_tvalid", 64'(m_loc_tvalid), 0);
    check("rst_m_loc_tlast", 64'(m_loc_tlast), 0);
    check("rst_s_loc_tready", 64'(s_loc_tready), 1);
    check("rst_m_res_tvalid", 64'(m_res_tvalid), 0);
    check("rst_m_res_tlast", 64'(m_res_tlast), 0);
    check("rst_m_res_terr", 64'(m_res_terr), 0);
    check("rst_m_res_time", 64'(m_res_time), 0);
    check("rst_m_res_tx", 64'(m_res_tx), 0);
    check("rst_m_res_tid", 64'(m_res_tid), 0);
    rst_n = 1'b1;
    tick();

    // Continuous contention: grants must rotate 0..3 twice.
    loc_lat = 3;
    for (int i = 0; i < N_REQ; i++) begin
      set_req(i, TIME_W'(1000 + i), XACC_W'((i + 1) * 1000), XACC_W'((i + 1) * 500), AACC_W'(10), i[0], 2);
    end
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < N_REQ; i++) begin
        push_exp(TIME_W'(1000 + i), XY_W'((i + 1) * 100), XY_W'((i + 1) * 50), ID_W'(i), i[0], 1'b0);
      end
    end
    drain(400);
    for (int i = 0; i < N_REQ; i++) check("fair_hs_cnt", 64'(hs_cnt[i]), 2);

    // Single request from requester 2, locator latency 33.
    loc_lat = 33;
    tick();
    set_req(2, 100, 500, 300, 10, 1'b1, 1);
    push_exp(100, 50, 30, 2, 1'b1, 1'b0);
    check("idle_tready", 64'(s_req_tready), 0);
    tick();
    check("grant_tready", 64'(s_req_tready), 64'(4'b0100));
    check("grant_loc_valid", 64'(m_loc_tvalid), 1);
    check("grant_loc_tx", 64'(m_loc_tx), 500);
    n = 0;
    while (!m_res_tvalid && n < 100) begin
      tick();
      n++;
    end
    check("res_latency", 64'(cyc - loc_fire_cyc), 1);
    drain(10);

    // Result backpressure for 20 cycles with two requesters pending.
    tick();
    m_res_tready = 1'b0;
    loc_lat = 4;
    set_req(3, 300, 2000, 900, 20, 1'b0, 1);
    set_req(1, 301, 777, 333, 3, 1'b1, 1);
    push_exp(300, 100, 45, 3, 1'b0, 1'b0);
    push_exp(301, 259, 111, 1, 1'b1, 1'b0);
    n = 0;
    while (!m_res_tvalid && n < 100) begin
      tick();
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      check("hold_valid", 64'(m_res_tvalid), 1);
      check("hold_tx", 64'(m_res_tx), 64'(exp_q[0].x));
      check("hold_time", 64'(m_res_time), 64'(exp_q[0].t));
      check("hold_no_tready", 64'(s_req_tready), 0);
      tick();
    end

    // Locator stalls for 5 cycles while requester 1 is in ISSUE.
    m_loc_tready = 1'b0;
    m_res_tready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_loc_valid", 64'(m_loc_tvalid), 1);
      check("stall_tready", 64'(s_req_tready), 0);
      tick();
    end
    m_loc_tready = 1'b1;
    #1;
    check("release_tready", 64'(s_req_tready), 64'(4'b0010));
    drain(50);

    // Reset during WAIT; the stale locator result must be dropped.
    tick();
    loc_lat = 20;
    set_req(2, 555, 1000, 2000, 100, 1'b0, 1);
    wait_loc_hs(20);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_mid_res_valid", 64'(m_res_tvalid), 0);
    check("rst_mid_tready", 64'(s_req_tready), 0);
    check("rst_mid_loc_valid", 64'(m_loc_tvalid), 0);
    rst_n = 1'b1;
    loc_cnt = 3;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("stale_drop", 64'(m_res_tvalid), 0);
    end
    set_req(3, 8, 880, 440, 8, 1'b1, 1);
    set_req(0, 7, 90, 45, 9, 1'b0, 1);
    push_exp(7, 10, 5, 0, 1'b0, 1'b0);
    push_exp(8, 110, 55, 3, 1'b1, 1'b0);
    tick();
    check("post_rst_grant", 64'(s_req_tready), 64'(4'b0001));
    drain(100);

`ifdef LOC_ARB_TIMEOUT_EN
    // Silent locator: watchdog result 65 cycles after WAIT entry, late result dropped.
    tick();
    loc_mute = 1'b1;
    m_res_tready = 1'b0;
    set_req(1, 42, 100, 100, 1, 1'b0, 1);
    push_exp(42, 0, 0, 1, 1'b0, 1'b1);
    wait_loc_hs(20);
    n = 0;
    while (!m_res_tvalid && n < 200) begin
      tick();
      n++;
    end
    check("wd_latency", 64'(n), 65);
    s_loc_tvalid = 1'b1;
    s_loc_tx = 7;
    s_loc_ty = 7;
    tick();
    m_res_tready = 1'b1;
    drain(10);
    for (int k = 0; k < 5; k++) tick();
    check("late_drop", 64'(m_res_tvalid), 0);
    loc_mute = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
